// File: rtl/wb_local_bridge_if.sv
`default_nettype none
// ===========================================================================
// wb_local_bridge_if : Wishbone classic slave port plus UserSpace local bus
// Rev 1.0
// ===========================================================================
interface wb_local_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wbAddress;
  logic [3:0]  wbByteSelect;
  logic        wbEnable;
  logic        wbWriteEnable;
  logic [31:0] wbDataWrite;
  logic [31:0] wbDataRead;
  logic        wbBusy;

  // Bridge side: Wishbone slave towards the CPU, local master towards UserSpace
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wbDataRead, wbBusy,
    output wb_ack_o, wb_dat_o,
    output wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wbDataRead, wbBusy,
    input  wb_ack_o, wb_dat_o,
    input  wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite
  );
endinterface
`default_nettype wire

// File: rtl/wb_local_bridge.sv
`default_nettype none
// ===========================================================================
// wb_local_bridge : Wishbone classic slave to UserSpace local bus bridge
// Rev 1.0
// ===========================================================================
module wb_local_bridge #(
  parameter int unsigned TIMEOUT_CYCLES      = 255,
  parameter int unsigned TIMEOUT_COUNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  wb_local_bridge_if.slave               bus,
  output logic                           timeoutPulse,
  output logic [TIMEOUT_COUNT_WIDTH-1:0] timeoutCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic [7:0]                     TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_COUNT_WIDTH-1:0] CNT_ONE       = TIMEOUT_COUNT_WIDTH'(1);

  state_t                         state_q, state_d;
  logic [7:0]                     busy_cnt_q, busy_cnt_d;
  logic [31:0]                    adr_q, adr_d;
  logic [3:0]                     sel_q, sel_d;
  logic                           we_q, we_d;
  logic [31:0]                    wdat_q, wdat_d;
  logic [31:0]                    rdat_q, rdat_d;
  logic                           pulse_q, pulse_d;
  logic [TIMEOUT_COUNT_WIDTH-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_cnt_q <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      pulse_q    <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      pulse_q    <= pulse_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    we_d       = we_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    pulse_d    = 1'b0;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          adr_d      = bus.wb_adr_i;
          sel_d      = bus.wb_sel_i;
          we_d       = bus.wb_we_i;
          wdat_d     = bus.wb_dat_i;
          busy_cnt_d = '0;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Abort beats completion, completion beats timeout
        if (!bus.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (!bus.wbBusy) begin
          rdat_d  = we_q ? 32'h0000_0000 : bus.wbDataRead;
          state_d = S_ACK;
        end else if (busy_cnt_q == TIMEOUT_LIMIT) begin
          rdat_d  = 32'hFFFF_FFFF;
          pulse_d = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + CNT_ONE;
          end
          state_d = S_ACK;
        end else begin
          busy_cnt_d = busy_cnt_q + 8'd1;
        end
      end
      // The ack cycle never samples a request, so a lingering strobe cannot re-trigger
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wb_ack_o      = (state_q == S_ACK);
  assign bus.wb_dat_o      = rdat_q;
  assign bus.wbEnable      = (state_q == S_ACCESS);
  assign bus.wbAddress     = adr_q;
  assign bus.wbByteSelect  = sel_q;
  assign bus.wbWriteEnable = we_q;
  assign bus.wbDataWrite   = wdat_q;
  assign timeoutPulse      = pulse_q;
  assign timeoutCount      = to_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_local_bridge.sv
`default_nettype none
// ===========================================================================
// tb_wb_local_bridge : cycle-timeline model bench for wb_local_bridge
// Rev 1.0
// ===========================================================================
module tb_wb_local_bridge;
  localparam int T     = 4;
  localparam int N_CYC = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       tPulse;
  logic [7:0] tCount;

  wb_local_bridge_if bus();

  wb_local_bridge #(.TIMEOUT_CYCLES(T), .TIMEOUT_COUNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .timeoutPulse (tPulse),
    .timeoutCount (tCount)
  );

  always #5 clk = ~clk;

  // cyc_n == k during the interval after rising edge k-1
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b1;

  // Expected output timeline, one entry per cycle
  bit        exp_en   [N_CYC];
  bit        exp_ack  [N_CYC];
  bit        exp_pulse[N_CYC];
  bit        exp_we   [N_CYC];
  bit [31:0] exp_adr  [N_CYC];
  bit [31:0] exp_wdat [N_CYC];
  bit [31:0] exp_dat  [N_CYC];
  bit [3:0]  exp_sel  [N_CYC];
  bit [7:0]  exp_cnt  [N_CYC];
  int        model_cnt = 0;

  int en_len, ack_off;
  bit pulse_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %h required %h", name, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run && cyc_n >= 1 && cyc_n < N_CYC) begin
      chk("wbEnable",      32'(bus.wbEnable),      32'(exp_en[cyc_n]));
      chk("wb_ack_o",      32'(bus.wb_ack_o),      32'(exp_ack[cyc_n]));
      chk("timeoutPulse",  32'(tPulse),            32'(exp_pulse[cyc_n]));
      chk("timeoutCount",  32'(tCount),            32'(exp_cnt[cyc_n]));
      chk("wb_dat_o",      bus.wb_dat_o,           exp_dat[cyc_n]);
      chk("wbAddress",     bus.wbAddress,          exp_adr[cyc_n]);
      chk("wbByteSelect",  32'(bus.wbByteSelect),  32'(exp_sel[cyc_n]));
      chk("wbWriteEnable", 32'(bus.wbWriteEnable), 32'(exp_we[cyc_n]));
      chk("wbDataWrite",   bus.wbDataWrite,        exp_wdat[cyc_n]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_fields(input int e, input bit we, input bit [31:0] adr,
                              input bit [3:0] sel, input bit [31:0] wdat);
    for (int c = e + 1; c < N_CYC; c++) begin
      exp_adr[c]  = adr;
      exp_sel[c]  = sel;
      exp_we[c]   = we;
      exp_wdat[c] = wdat;
    end
  endtask

  task automatic sched_done(input int a, input bit to, input bit [31:0] d);
    exp_ack[a]   = 1'b1;
    exp_pulse[a] = to;
    for (int c = a; c < N_CYC; c++) exp_dat[c] = d;
    if (to) begin
      if (model_cnt < 255) model_cnt++;
      for (int c = a; c < N_CYC; c++) exp_cnt[c] = 8'(model_cnt);
    end
  endtask

  // Request driven in cycle e, sampled at edge e; slave busy for nbusy ACCESS cycles
  task automatic txn(input bit we, input bit [31:0] adr, input bit [3:0] sel,
                     input bit [31:0] wdat, input bit [31:0] rd, input int nbusy,
                     input bit keep);
    int e, k;
    bit to;
    e  = cyc_n;
    to = (nbusy > T);
    k  = to ? T + 1 : nbusy + 1;
    for (int c = e + 1; c <= e + k; c++) exp_en[c] = 1'b1;
    sched_fields(e, we, adr, sel, wdat);
    sched_done(e + k + 1, to, to ? 32'hFFFF_FFFF : (we ? 32'h0 : rd));
    bus.wb_cyc_i   = 1'b1;
    bus.wb_stb_i   = 1'b1;
    bus.wb_we_i    = we;
    bus.wb_adr_i   = adr;
    bus.wb_sel_i   = sel;
    bus.wb_dat_i   = wdat;
    bus.wbDataRead = rd;
    bus.wbBusy     = 1'b0;
    en_len = 0; ack_off = 0; pulse_seen = 1'b0;
    for (int i = 1; i <= k + 1; i++) begin
      step();
      bus.wbBusy = (i <= k) && (i <= nbusy);
      if (bus.wbEnable) en_len++;
      if (bus.wb_ack_o) ack_off = i;
      if (tPulse) pulse_seen = 1'b1;
    end
    step();
    bus.wbBusy = 1'b0;
    if (!keep) begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0; bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0;
    bus.wbDataRead = 32'h0; bus.wbBusy = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Zero-wait read
    txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'h0000_0013, 0, 1'b0);
    chk("t1_en_len",  32'(en_len),  32'd1);
    chk("t1_ack_off", 32'(ack_off), 32'd2);
    chk("t1_rdata",   bus.wb_dat_o, 32'h0000_0013);

    // Write with three busy cycles
    txn(1'b1, 32'h3000_0000, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b0);
    chk("t2_en_len",  32'(en_len),     32'd4);
    chk("t2_ack_off", 32'(ack_off),    32'd5);
    chk("t2_wdat0",   bus.wb_dat_o,    32'h0);
    chk("t2_pulse",   32'(pulse_seen), 32'd0);
    chk("t2_adr",     bus.wbAddress,   32'h3000_0000);

    // Stuck slave times out
    txn(1'b0, 32'h3000_0020, 4'h3, 32'h0, 32'h5555_5555, 1000, 1'b0);
    chk("t3_en_len",  32'(en_len),     32'd5);
    chk("t3_ack_off", 32'(ack_off),    32'd6);
    chk("t3_dat",     bus.wb_dat_o,    32'hFFFF_FFFF);
    chk("t3_pulse",   32'(pulse_seen), 32'd1);
    chk("t3_count",   32'(tCount),     32'd1);

    // Completion exactly on the timeout boundary
    txn(1'b0, 32'h3000_0024, 4'hC, 32'h0, 32'hCAFE_0004, T, 1'b0);
    chk("t4_ack_off", 32'(ack_off),    32'd6);
    chk("t4_dat",     bus.wb_dat_o,    32'hCAFE_0004);
    chk("t4_pulse",   32'(pulse_seen), 32'd0);
    chk("t4_count",   32'(tCount),     32'd1);

    // Back-to-back reads with cyc/stb held
    txn(1'b0, 32'h3000_0030, 4'hF, 32'h0, 32'hAAAA_0001, 1, 1'b1);
    chk("t5_en_during_ack", 32'(bus.wbEnable), 32'd0);
    txn(1'b0, 32'h3000_0034, 4'hF, 32'h0, 32'hAAAA_0002, 0, 1'b0);
    chk("t5_ack_off2", 32'(ack_off), 32'd2);
    chk("t5_dat2",     bus.wb_dat_o, 32'hAAAA_0002);

    // Abort: cyc dropped in busy cycle 2
    begin
      int e;
      e = cyc_n;
      for (int c = e + 1; c <= e + 2; c++) exp_en[c] = 1'b1;
      sched_fields(e, 1'b1, 32'h3000_0040, 4'h1, 32'h0BAD_0BAD);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_adr_i = 32'h3000_0040; bus.wb_sel_i = 4'h1; bus.wb_dat_i = 32'h0BAD_0BAD;
      for (int i = 1; i <= 2; i++) begin
        step();
        bus.wbBusy = 1'b1;
        if (i == 2) begin
          bus.wb_cyc_i = 1'b0;
          bus.wb_stb_i = 1'b0;
        end
      end
      step();
      chk("t6_en_after_abort", 32'(bus.wbEnable), 32'd0);
      bus.wbBusy = 1'b0;
      step();
      step();
      chk("t6_no_ack", 32'(bus.wb_ack_o), 32'd0);
    end

    // Reset in the middle of an access
    begin
      int e;
      e = cyc_n;
      for (int c = e + 1; c <= e + 2; c++) exp_en[c] = 1'b1;
      sched_fields(e, 1'b0, 32'h3000_0050, 4'hF, 32'h0);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = 32'h3000_0050; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h0;
      for (int i = 1; i <= 2; i++) begin
        step();
        bus.wbBusy = 1'b1;
      end
      rst = 1'b1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      for (int c = e + 3; c < N_CYC; c++) begin
        exp_en[c] = 1'b0; exp_ack[c] = 1'b0; exp_pulse[c] = 1'b0; exp_we[c] = 1'b0;
        exp_adr[c] = 32'h0; exp_wdat[c] = 32'h0; exp_dat[c] = 32'h0;
        exp_sel[c] = 4'h0; exp_cnt[c] = 8'h0;
      end
      model_cnt = 0;
      step();
      rst = 1'b0;
      bus.wbBusy = 1'b0;
      chk("t7_en_rst",  32'(bus.wbEnable), 32'd0);
      chk("t7_adr_rst", bus.wbAddress,     32'h0);
      chk("t7_cnt_rst", 32'(tCount),       32'd0);
    end
    txn(1'b0, 32'h3000_0060, 4'hF, 32'h0, 32'h6060_6060, 2, 1'b0);
    chk("t7_after_ack_off", 32'(ack_off), 32'd4);
    chk("t7_after_dat",     bus.wb_dat_o, 32'h6060_6060);

    // Saturation of the timeout counter
    for (int n = 0; n < 256; n++) begin
      txn(1'b0, 32'h3000_1000 + 32'(n), 4'hF, 32'h0, 32'h0, 1000, 1'b0);
    end
    chk("t8_count_sat", 32'(tCount), 32'd255);

    step();
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
